// File: rtl/seletor_de_coordenadas_pkg.sv
`default_nettype none
// ============================================================================
// Module : seletor_de_coordenadas_pkg
// Brief  : Board geometry, cursor FSM encodings and wrap-around helper.
// Rev    : 1.0
// ============================================================================
package seletor_de_coordenadas_pkg;

    localparam int N_COLUNAS = 5;
    localparam int N_LINHAS  = 7;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        CONFIRMANDO = 2'd1,
        BLOQUEADO   = 2'd2
    } estado_t;

    function automatic logic [2:0] incrementa_wrap(input logic [2:0] v, input logic [2:0] max);
        return (v == max) ? 3'd0 : v + 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seletor_de_coordenadas_if.sv
`default_nettype none
// ============================================================================
// Module : seletor_de_coordenadas_if
// Brief  : Buttons/enable in, cursor coordinates and confirm pulse out.
// Rev    : 1.0
// ============================================================================
interface seletor_de_coordenadas_if;

    logic       enable;
    logic       btn_coluna;
    logic       btn_linha;
    logic       btn_confirmar;
    logic [2:0] coordColuna;
    logic [2:0] coordLinha;
    logic       confirmar;
    logic       cursor_pisca;

    modport master (
        output enable, btn_coluna, btn_linha, btn_confirmar,
        input  coordColuna, coordLinha, confirmar, cursor_pisca
    );

    modport slave (
        input  enable, btn_coluna, btn_linha, btn_confirmar,
        output coordColuna, coordLinha, confirmar, cursor_pisca
    );

endinterface
`default_nettype wire

// File: rtl/seletor_de_coordenadas_debouncer_botao.sv
`default_nettype none
// ============================================================================
// Module : debouncer_botao
// Brief  : Synchronises an active-low button, debounces it, flags new presses.
// Rev    : 1.0
// ============================================================================
module debouncer_botao #(
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic raw_n,
    output logic      nivel,
    output logic      pressionou
);

    localparam int              CW         = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0]   c_CONT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    logic          r_sinc1;
    logic          r_sinc2;
    logic          r_nivel;
    logic [CW-1:0] r_cnt;
    logic          w_vira;

    // The accepted level flips on the sample that completes the run.
    assign w_vira = (r_sinc2 != r_nivel) && (r_cnt == c_CONT_MAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sinc1 <= 1'b0;
            r_sinc2 <= 1'b0;
            r_nivel <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sinc1 <= ~raw_n;
            r_sinc2 <= r_sinc1;
            if (r_sinc2 == r_nivel) begin
                r_cnt <= '0;
            end else if (w_vira) begin
                r_nivel <= r_sinc2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign nivel      = r_nivel;
    assign pressionou = w_vira & r_sinc2;

endmodule
`default_nettype wire

// File: rtl/seletor_de_coordenadas.sv
`default_nettype none
// ============================================================================
// Module : seletor_de_coordenadas
// Brief  : Button-driven board cursor with wrap-around, confirm pulse and blink.
// Rev    : 1.0
// ============================================================================
module seletor_de_coordenadas
    import seletor_de_coordenadas_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int CONFIRMA_CICLOS = 2,
    parameter int PISCA_CICLOS    = 8
) (
    input  wire logic               clock,
    input  wire logic               reset,
    seletor_de_coordenadas_if.slave bus
);

    localparam int             CCW         = (CONFIRMA_CICLOS > 1) ? $clog2(CONFIRMA_CICLOS) : 1;
    localparam int             PW          = (PISCA_CICLOS > 1) ? $clog2(PISCA_CICLOS) : 1;
    localparam logic [CCW-1:0] c_CONF_MAX  = CCW'(CONFIRMA_CICLOS - 1);
    localparam logic [PW-1:0]  c_PISCA_MAX = PW'(PISCA_CICLOS - 1);
    localparam logic [2:0]     c_COL_MAX   = 3'(N_COLUNAS - 1);
    localparam logic [2:0]     c_LIN_MAX   = 3'(N_LINHAS - 1);

    logic w_p_col, w_p_lin, w_p_conf, w_nivel_conf;

    debouncer_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_db_coluna (
        .clock(clock), .reset(reset), .raw_n(bus.btn_coluna),
        .nivel(), .pressionou(w_p_col)
    );
    debouncer_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_db_linha (
        .clock(clock), .reset(reset), .raw_n(bus.btn_linha),
        .nivel(), .pressionou(w_p_lin)
    );
    debouncer_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_db_confirmar (
        .clock(clock), .reset(reset), .raw_n(bus.btn_confirmar),
        .nivel(w_nivel_conf), .pressionou(w_p_conf)
    );

    estado_t        r_estado, w_estado;
    logic [2:0]     r_col, w_col;
    logic [2:0]     r_lin, w_lin;
    logic           r_conf, w_conf;
    logic [CCW-1:0] r_cnt_conf, w_cnt_conf;
    logic [PW-1:0]  r_cnt_pisca;
    logic           r_pisca;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado   <= OCIOSO;
            r_col      <= 3'd0;
            r_lin      <= 3'd0;
            r_conf     <= 1'b0;
            r_cnt_conf <= '0;
        end else begin
            r_estado   <= w_estado;
            r_col      <= w_col;
            r_lin      <= w_lin;
            r_conf     <= w_conf;
            r_cnt_conf <= w_cnt_conf;
        end
    end

    always_comb begin
        w_estado   = r_estado;
        w_col      = r_col;
        w_lin      = r_lin;
        w_conf     = 1'b0;
        w_cnt_conf = r_cnt_conf;
        if (!bus.enable) begin
            w_estado   = OCIOSO;
            w_col      = 3'd0;
            w_lin      = 3'd0;
            w_cnt_conf = '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    // A confirm press takes priority and drops same-cycle increments.
                    if (w_p_conf) begin
                        w_estado   = CONFIRMANDO;
                        w_conf     = 1'b1;
                        w_cnt_conf = '0;
                    end else begin
                        if (w_p_col) w_col = incrementa_wrap(r_col, c_COL_MAX);
                        if (w_p_lin) w_lin = incrementa_wrap(r_lin, c_LIN_MAX);
                    end
                end
                CONFIRMANDO: begin
                    if (r_cnt_conf == c_CONF_MAX) begin
                        w_estado   = BLOQUEADO;
                        w_cnt_conf = '0;
                    end else begin
                        w_conf     = 1'b1;
                        w_cnt_conf = r_cnt_conf + CCW'(1);
                    end
                end
                BLOQUEADO: begin
                    if (!w_nivel_conf) w_estado = OCIOSO;
                end
                default: w_estado = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt_pisca <= '0;
            r_pisca     <= 1'b0;
        end else if (!bus.enable) begin
            r_cnt_pisca <= '0;
            r_pisca     <= 1'b0;
        end else if (r_cnt_pisca == c_PISCA_MAX) begin
            r_cnt_pisca <= '0;
            r_pisca     <= ~r_pisca;
        end else begin
            r_cnt_pisca <= r_cnt_pisca + PW'(1);
        end
    end

    assign bus.coordColuna  = r_col;
    assign bus.coordLinha   = r_lin;
    assign bus.confirmar    = r_conf;
    assign bus.cursor_pisca = r_pisca;

endmodule
`default_nettype wire

// File: tb/tb_seletor_de_coordenadas.sv
`default_nettype none
// ============================================================================
// Module : tb_seletor_de_coordenadas
// Brief  : Directed self-checking bench for the cursor selector.
// Rev    : 1.0
// ============================================================================
module tb_seletor_de_coordenadas;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    seletor_de_coordenadas_if bus ();

    seletor_de_coordenadas #(
        .DEBOUNCE_CICLOS(4), .CONFIRMA_CICLOS(2), .PISCA_CICLOS(8)
    ) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: bus.btn_coluna    = v;
            1: bus.btn_linha     = v;
            default: bus.btn_confirmar = v;
        endcase
    endtask

    task automatic press_btn(input int which);
        set_btn(which, 1'b0);
        repeat (6) @(negedge clock);
        set_btn(which, 1'b1);
        repeat (8) @(negedge clock);
    endtask

    task automatic test_reset;
        bus.enable = 1'b0; bus.btn_coluna = 1'b1; bus.btn_linha = 1'b1; bus.btn_confirmar = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_tests++; if (bus.coordColuna !== 3'd0) begin n_fail++; $display("FAIL reset_col got=%0d exp=0", bus.coordColuna); end
        n_tests++; if (bus.coordLinha !== 3'd0) begin n_fail++; $display("FAIL reset_lin got=%0d exp=0", bus.coordLinha); end
        n_tests++; if (bus.confirmar !== 1'b0) begin n_fail++; $display("FAIL reset_conf got=%b exp=0", bus.confirmar); end
        n_tests++; if (bus.cursor_pisca !== 1'b0) begin n_fail++; $display("FAIL reset_pisca got=%b exp=0", bus.cursor_pisca); end
        reset = 1'b1;
        bus.enable = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_wrap;
        logic [2:0] exp_col [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        logic [2:0] exp_lin [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
        for (int i = 0; i < 5; i++) begin
            bus.btn_coluna = 1'b0;
            repeat (6) @(negedge clock);
            n_tests++;
            if (bus.coordColuna !== exp_col[i]) begin
                n_fail++; $display("FAIL wrap_col[%0d] got=%0d exp=%0d", i, bus.coordColuna, exp_col[i]);
            end
            bus.btn_coluna = 1'b1;
            repeat (8) @(negedge clock);
        end
        for (int i = 0; i < 7; i++) begin
            bus.btn_linha = 1'b0;
            repeat (6) @(negedge clock);
            n_tests++;
            if (bus.coordLinha !== exp_lin[i]) begin
                n_fail++; $display("FAIL wrap_lin[%0d] got=%0d exp=%0d", i, bus.coordLinha, exp_lin[i]);
            end
            bus.btn_linha = 1'b1;
            repeat (8) @(negedge clock);
        end
    endtask

    task automatic test_bounce;
        for (int i = 0; i < 3; i++) begin
            bus.btn_coluna = 1'b0; repeat (2) @(negedge clock);
            bus.btn_coluna = 1'b1; repeat (2) @(negedge clock);
        end
        n_tests++; if (bus.coordColuna !== 3'd0) begin n_fail++; $display("FAIL bounce_during got=%0d exp=0", bus.coordColuna); end
        bus.btn_coluna = 1'b0;
        repeat (5) @(negedge clock);
        n_tests++; if (bus.coordColuna !== 3'd0) begin n_fail++; $display("FAIL bounce_early got=%0d exp=0", bus.coordColuna); end
        @(negedge clock);
        n_tests++; if (bus.coordColuna !== 3'd1) begin n_fail++; $display("FAIL bounce_step got=%0d exp=1", bus.coordColuna); end
        repeat (10) @(negedge clock);
        n_tests++; if (bus.coordColuna !== 3'd1) begin n_fail++; $display("FAIL bounce_hold got=%0d exp=1", bus.coordColuna); end
        bus.btn_coluna = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic test_confirm;
        int rises;
        int highs;
        logic prev;
        press_btn(0);
        for (int i = 0; i < 4; i++) press_btn(1);
        n_tests++; if ({bus.coordColuna, bus.coordLinha} !== {3'd2, 3'd4}) begin n_fail++; $display("FAIL conf_setup got=(%0d,%0d) exp=(2,4)", bus.coordColuna, bus.coordLinha); end
        bus.btn_confirmar = 1'b0;
        repeat (5) @(negedge clock);
        n_tests++; if (bus.confirmar !== 1'b0) begin n_fail++; $display("FAIL conf_early got=%b exp=0", bus.confirmar); end
        @(negedge clock);
        n_tests++; if (bus.confirmar !== 1'b1) begin n_fail++; $display("FAIL conf_rise got=%b exp=1", bus.confirmar); end
        n_tests++; if ({bus.coordColuna, bus.coordLinha} !== {3'd2, 3'd4}) begin n_fail++; $display("FAIL conf_coords got=(%0d,%0d) exp=(2,4)", bus.coordColuna, bus.coordLinha); end
        @(negedge clock);
        n_tests++; if (bus.confirmar !== 1'b1) begin n_fail++; $display("FAIL conf_second got=%b exp=1", bus.confirmar); end
        @(negedge clock);
        n_tests++; if (bus.confirmar !== 1'b0) begin n_fail++; $display("FAIL conf_fall got=%b exp=0", bus.confirmar); end
        // Held confirm: no further pulse, and a column press meanwhile is ignored.
        rises = 0; prev = 1'b0;
        bus.btn_coluna = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (i == 20) bus.btn_coluna = 1'b1;
            @(negedge clock);
            if (bus.confirmar && !prev) rises++;
            prev = bus.confirmar;
        end
        n_tests++; if (rises !== 0) begin n_fail++; $display("FAIL conf_held_pulses got=%0d exp=0", rises); end
        n_tests++; if (bus.coordColuna !== 3'd2) begin n_fail++; $display("FAIL conf_blocked_col got=%0d exp=2", bus.coordColuna); end
        bus.btn_confirmar = 1'b1;
        repeat (8) @(negedge clock);
        bus.btn_confirmar = 1'b0;
        rises = 0; highs = 0; prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (bus.confirmar && !prev) rises++;
            if (bus.confirmar) highs++;
            prev = bus.confirmar;
        end
        n_tests++; if (rises !== 1) begin n_fail++; $display("FAIL conf_repress_pulses got=%0d exp=1", rises); end
        n_tests++; if (highs !== 2) begin n_fail++; $display("FAIL conf_repress_width got=%0d exp=2", highs); end
        bus.btn_confirmar = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic test_reset_async;
        press_btn(0);
        press_btn(1);
        n_tests++; if ({bus.coordColuna, bus.coordLinha} !== {3'd3, 3'd5}) begin n_fail++; $display("FAIL rst_setup got=(%0d,%0d) exp=(3,5)", bus.coordColuna, bus.coordLinha); end
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_tests++; if ({bus.coordColuna, bus.coordLinha} !== {3'd0, 3'd0}) begin n_fail++; $display("FAIL rst_async_coords got=(%0d,%0d) exp=(0,0)", bus.coordColuna, bus.coordLinha); end
        n_tests++; if (bus.confirmar !== 1'b0) begin n_fail++; $display("FAIL rst_async_conf got=%b exp=0", bus.confirmar); end
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_simultaneous;
        bus.btn_coluna = 1'b0; bus.btn_linha = 1'b0;
        repeat (6) @(negedge clock);
        n_tests++; if ({bus.coordColuna, bus.coordLinha} !== {3'd1, 3'd1}) begin n_fail++; $display("FAIL simul_colrow got=(%0d,%0d) exp=(1,1)", bus.coordColuna, bus.coordLinha); end
        bus.btn_coluna = 1'b1; bus.btn_linha = 1'b1;
        repeat (8) @(negedge clock);
        bus.btn_coluna = 1'b0; bus.btn_confirmar = 1'b0;
        repeat (6) @(negedge clock);
        n_tests++; if (bus.confirmar !== 1'b1) begin n_fail++; $display("FAIL simul_conf got=%b exp=1", bus.confirmar); end
        n_tests++; if (bus.coordColuna !== 3'd1) begin n_fail++; $display("FAIL simul_col_rise got=%0d exp=1", bus.coordColuna); end
        bus.btn_coluna = 1'b1; bus.btn_confirmar = 1'b1;
        repeat (10) @(negedge clock);
        n_tests++; if ({bus.coordColuna, bus.coordLinha} !== {3'd1, 3'd1}) begin n_fail++; $display("FAIL simul_after got=(%0d,%0d) exp=(1,1)", bus.coordColuna, bus.coordLinha); end
    endtask

    task automatic test_enable;
        int rises;
        logic prev;
        bus.btn_confirmar = 1'b0;
        repeat (6) @(negedge clock);
        n_tests++; if (bus.confirmar !== 1'b1) begin n_fail++; $display("FAIL en_conf_rise got=%b exp=1", bus.confirmar); end
        bus.enable = 1'b0;
        @(negedge clock);
        n_tests++; if (bus.confirmar !== 1'b0) begin n_fail++; $display("FAIL en_truncate got=%b exp=0", bus.confirmar); end
        n_tests++; if ({bus.coordColuna, bus.coordLinha} !== {3'd0, 3'd0}) begin n_fail++; $display("FAIL en_coords got=(%0d,%0d) exp=(0,0)", bus.coordColuna, bus.coordLinha); end
        n_tests++; if (bus.cursor_pisca !== 1'b0) begin n_fail++; $display("FAIL en_pisca got=%b exp=0", bus.cursor_pisca); end
        repeat (4) @(negedge clock);
        bus.enable = 1'b1;
        rises = 0; prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.confirmar && !prev) rises++;
            prev = bus.confirmar;
        end
        n_tests++; if (rises !== 0) begin n_fail++; $display("FAIL en_held_pulses got=%0d exp=0", rises); end
        bus.btn_confirmar = 1'b1;
        repeat (8) @(negedge clock);
        bus.btn_confirmar = 1'b0;
        repeat (6) @(negedge clock);
        n_tests++; if (bus.confirmar !== 1'b1) begin n_fail++; $display("FAIL en_repress got=%b exp=1", bus.confirmar); end
        bus.btn_confirmar = 1'b1;
        repeat (10) @(negedge clock);
    endtask

    task automatic test_pisca;
        bus.enable = 1'b0;
        repeat (2) @(negedge clock);
        n_tests++; if (bus.cursor_pisca !== 1'b0) begin n_fail++; $display("FAIL pisca_off got=%b exp=0", bus.cursor_pisca); end
        bus.enable = 1'b1;
        repeat (7) @(negedge clock);
        n_tests++; if (bus.cursor_pisca !== 1'b0) begin n_fail++; $display("FAIL pisca_7 got=%b exp=0", bus.cursor_pisca); end
        @(negedge clock);
        n_tests++; if (bus.cursor_pisca !== 1'b1) begin n_fail++; $display("FAIL pisca_8 got=%b exp=1", bus.cursor_pisca); end
        repeat (7) @(negedge clock);
        n_tests++; if (bus.cursor_pisca !== 1'b1) begin n_fail++; $display("FAIL pisca_15 got=%b exp=1", bus.cursor_pisca); end
        @(negedge clock);
        n_tests++; if (bus.cursor_pisca !== 1'b0) begin n_fail++; $display("FAIL pisca_16 got=%b exp=0", bus.cursor_pisca); end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_bounce();
        test_confirm();
        test_reset_async();
        test_simultaneous();
        test_enable();
        test_pisca();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
